dsmod2: RTL

Parametrised delta-sigma DAC modulator. It converts a signed n-bit sample stream into a 1-bit pulse-density output, with selectable loop order: first order, or second order with an error-feedback structure and noise transfer function (1 − z⁻¹)². It adds a clock enable and a sticky overload flag with saturating error state. It sits between a sample source (NCO, audio path, PWM replacement) and an output pin followed by an analogue RC filter.

---
 rtl/dsmod2_pkg.sv | 15 +
 rtl/dsmod2_if.sv | 19 +
 rtl/dsmod_sat.sv | 31 +++
 rtl/dsmod2.sv | 96 +++++++++
 4 files changed

// File: rtl/dsmod2_pkg.sv
// rtl/dsmod2_pkg.sv - shared constants and helpers for the dsmod2 delta-sigma modulator
package dsmod2_pkg;

  // Extra bits on top of the sample width for the loop-filter sum:
  // in + 2*e1 - e2 spans roughly +/-7F, so n+4 bits hold it without wrap.
  localparam int GUARD_BITS = 4;

  // Error state width above the sample width (holds [-4F, 4F-1]).
  localparam int STATE_EXTRA = 2;

  function automatic bit order_valid(input int order);
    return (order == 1) || (order == 2);
  endfunction

endpackage

// File: rtl/dsmod2_if.sv
// rtl/dsmod2_if.sv - sample/control/output bundle for dsmod2
// Ports:
//   ce      - clock enable, modulator steps on enabled edges
//   in      - signed n-bit input sample
//   ovf_clr - synchronous clear of the sticky overload flag
//   out     - registered pulse-density bit
//   ovf     - sticky overload flag
interface dsmod2_if #(
  parameter int n = 4
);
  logic                ce;
  logic signed [n-1:0] in;
  logic                ovf_clr;
  logic                out;
  logic                ovf;

  modport master (output ce, in, ovf_clr, input out, ovf);
  modport slave  (input ce, in, ovf_clr, output out, ovf);
endinterface

// File: rtl/dsmod_sat.sv
// rtl/dsmod_sat.sv - combinational signed clamp from IW bits to the OW-bit range
// Ports:
//   din     - signed IW-bit value
//   dout    - din clamped to [-2^(OW-1), 2^(OW-1)-1]
//   clamped - high when din was outside that range
module dsmod_sat #(
  parameter int IW = 8,
  parameter int OW = 5
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clamped
);

  // Output-range limits expressed at the input width for a signed compare.
  localparam logic signed [IW-1:0] MAX_I = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_I = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    dout    = din[OW-1:0];
    clamped = 1'b0;
    if (din > MAX_I) begin
      dout    = MAX_I[OW-1:0];
      clamped = 1'b1;
    end else if (din < MIN_I) begin
      dout    = MIN_I[OW-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/dsmod2.sv
// rtl/dsmod2.sv - first/second order delta-sigma DAC modulator with sticky overload flag
// Ports:
//   clk - system clock, rising edge
//   clr - asynchronous active-high reset
//   bus - dsmod2_if.slave: ce, in, ovf_clr in; out, ovf out
// Parameters: n (sample width, >= 2), ORDER (1 or 2).
module dsmod2
  import dsmod2_pkg::*;
#(
  parameter int n     = 4,
  parameter int ORDER = 2
) (
  input  logic     clk,
  input  logic     clr,
  dsmod2_if.slave  bus
);

  localparam int VW = n + GUARD_BITS;
  localparam int EW = n + STATE_EXTRA;

  // Feedback magnitude F = 2^(n-1) at loop-filter width.
  localparam logic signed [VW-1:0] F = {{(VW-n){1'b0}}, 1'b1, {(n-1){1'b0}}};

  if (!order_valid(ORDER)) begin : g_order_err
    $fatal(1, "dsmod2: ORDER must be 1 or 2");
  end

  logic signed [EW-1:0] e1_q, e1_d, e2_q, e2_d;
  logic                 out_q, out_d, ovf_q, ovf_d;

  logic signed [VW-1:0] in_x, e1_x, e2_x, v, q, e_raw;
  logic signed [n:0]    e_sat;
  logic                 clamp;
  logic                 y;

  // Error is clamped to [-2F, 2F-1], i.e. the range of an (n+1)-bit value.
  dsmod_sat #(.IW(VW), .OW(n + 1)) u_sat (
    .din     (e_raw),
    .dout    (e_sat),
    .clamped (clamp)
  );

  always_comb begin
    in_x = {{(VW-n){bus.in[n-1]}}, bus.in};
    e1_x = {{(VW-EW){e1_q[EW-1]}}, e1_q};
    e2_x = {{(VW-EW){e2_q[EW-1]}}, e2_q};

    if (ORDER == 2) begin
      v = in_x + (e1_x <<< 1) - e2_x;   // NTF (1 - z^-1)^2
    end else begin
      v = in_x + e1_x;
    end

    y     = ~v[VW-1];
    q     = y ? F : -F;
    e_raw = v - q;
  end

  always_comb begin
    e1_d  = e1_q;
    e2_d  = e2_q;
    out_d = out_q;
    ovf_d = ovf_q;

    if (bus.ce) begin
      e1_d  = {e_sat[n], e_sat};
      e2_d  = (ORDER == 2) ? e1_q : '0;
      out_d = y;
    end

    // A clamp on this edge wins over a coincident clear; clear ignores ce.
    if (bus.ce && clamp) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      e1_q  <= '0;
      e2_q  <= '0;
      out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out = out_q;
  assign bus.ovf = ovf_q;

endmodule
